multilane_processing_element: RTL
=================================

// Module: multilane_processing_element
// PURPOSE
//  Next-generation systolic PE. Holds LANES signed weights and computes the dot product of the
//  weights with LANES input samples, plus an incoming partial sum or an internal accumulator.
//  Two-stage pipeline with a valid strobe. Instantiated in a chain along a row of the array;
//  weights are loaded by address broadcast over the shared i_addr bus.
// PARAMETERS
//  WEIGHT_BW    8   signed weight width per lane
//  DATA_BW      8   signed data width per lane
//  SUM_BW       16  signed incoming partial-sum width
//  OUT_BW       20  signed output width; must be >= SUM_BW+1
//  ADDR_BW      5   weight-load address width
//  LANES        4   parallel multiply lanes (>=1)
//  ELEMENT_ADDR 0   address this PE responds to on weight load
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-high
//  i_w_en     in   1                  weight-load strobe
//  i_addr     in   ADDR_BW            weight-load target address
//  i_w        in   LANES*WEIGHT_BW    packed weights; lane k = bits [k*WEIGHT_BW +: WEIGHT_BW]
//  i_valid    in   1                  input beat valid
//  i_x        in   LANES*DATA_BW      packed signed samples, same lane packing as i_w
//  i_psum     in   SUM_BW             signed upstream partial sum
//  i_acc_mode in   1                  1 = add to internal accumulator instead of i_psum
//  i_acc_clr  in   1                  with i_acc_mode: start a new accumulation at 0
//  o_valid    out  1                  output beat valid
//  o_psum     out  OUT_BW             signed result
// BEHAVIOUR
//  - Reset clears all weights, both pipeline stages, o_valid and o_psum to 0. Reset mid-stream
//    discards in-flight beats; no o_valid pulse is produced for them.
//  - Weight load: if i_w_en=1 and i_addr==ELEMENT_ADDR, all LANES weights update on that edge.
//    Any other address is ignored.
//  - Stage 1 (on an edge with i_valid=1): register the LANES full-width products
//    (WEIGHT_BW+DATA_BW bits each), i_psum sign-extended, i_acc_mode and i_acc_clr.
//    Stage-1 valid <= i_valid.
//  - Stage 2: sum = sign-extended sum of all products. If stage-1 valid=1, o_psum becomes:
//    * mode 0:               psum + sum
//    * mode 1, clr=1:        0 + sum
//    * mode 1, clr=0:        o_psum + sum
//    o_valid <= stage-1 valid.
//  - Latency: 2 cycles, i_valid to o_valid. Throughput is 1 beat per cycle. No backpressure.
//  - o_psum holds its value while o_valid=0. Bubbles never disturb the accumulator.
//  - Same-edge weight load and i_valid: the beat uses the OLD weights; the new weights apply
//    from the next beat onward.
//  - i_acc_clr is ignored when i_acc_mode=0. Switching modes between beats is legal.
//  - Arithmetic: internal sums carry enough headroom for no loss before the final narrowing;
//    the final result wraps modulo 2^OUT_BW (two's complement).
// CONFIGURATION
//  PE_SATURATE_EN defined: the final result clamps to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1]. In
//  accumulate mode the clamped value is what is held in the accumulator.
//  PE_SATURATE_EN undefined: wrap as described above. Ports are identical in both builds.
// TESTING
//  1 Reset: weights 0, i_x=5 on all lanes, i_psum=7, mode 0 -> o_valid pulses 2 cycles later
//    with o_psum=7.
//  2 Load at ELEMENT_ADDR {1,2,3,4}, then i_x={1,1,1,1}, i_psum=10 -> o_psum=20. A load at
//    another address leaves the weights unchanged.
//  3 Valid pattern 1,1,0,1 with distinct i_x values -> o_valid pattern 1,1,0,1 two cycles
//    later, with matching sums; o_psum held through the gap.
//  4 Acc mode, weights {1,1,1,1}, i_x=2 on all lanes, clr on beat 0, four beats ->
//    8,16,24,32; a further beat with clr=1 -> 8.
//  5 OUT_BW=18, weights -128 and i_x -128 on all lanes (sum 65536), acc mode three beats ->
//    65536, 131072 wraps to -131072, then -65536; with PE_SATURATE_EN -> 65536, 131071,
//    131071.
//  6 Same-edge load of weights 2 with a beat x=1 (old weights 1) -> 4, next beat -> 8.
//    Assert rst with 2 beats in flight -> no o_valid, o_psum=0.

Source files
------------

// File: rtl/multilane_processing_element.sv
// Systolic PE: LANES-wide signed dot product plus upstream psum or local accumulator, 2-stage pipeline.
// Define PE_SATURATE_EN to clamp the result to the OUT_BW signed range instead of wrapping.
module multilane_processing_element #(
    parameter int WEIGHT_BW    = 8,
    parameter int DATA_BW      = 8,
    parameter int SUM_BW       = 16,
    parameter int OUT_BW       = 20,
    parameter int ADDR_BW      = 5,
    parameter int LANES        = 4,
    parameter int ELEMENT_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_w_en,
    input  logic [ADDR_BW-1:0]           i_addr,
    input  logic [LANES*WEIGHT_BW-1:0]   i_w,
    input  logic                         i_valid,
    input  logic [LANES*DATA_BW-1:0]     i_x,
    input  logic [SUM_BW-1:0]            i_psum,
    input  logic                         i_acc_mode,
    input  logic                         i_acc_clr,
    output logic                         o_valid,
    output logic [OUT_BW-1:0]            o_psum
);
    localparam int PROD_BW = WEIGHT_BW + DATA_BW;
`ifdef PE_SATURATE_EN
    // Wide enough to hold the unclamped total so the clamp decision is exact.
    localparam int CALC_BW = OUT_BW + PROD_BW + $clog2(LANES + 1) + 2;
`else
    // Wrapping only needs the low OUT_BW bits; modular arithmetic keeps them exact.
    localparam int CALC_BW = OUT_BW;
`endif

    logic signed [WEIGHT_BW-1:0] w_q    [LANES];
    logic signed [WEIGHT_BW-1:0] w_d    [LANES];
    logic signed [PROD_BW-1:0]   prod_q [LANES];
    logic signed [PROD_BW-1:0]   prod_d [LANES];
    logic signed [SUM_BW-1:0]    psum1_q, psum1_d;
    logic                        mode1_q, mode1_d;
    logic                        clr1_q, clr1_d;
    logic                        v1_q, v1_d;
    logic                        v2_q, v2_d;
    logic [OUT_BW-1:0]           psum2_q, psum2_d;

    logic signed [WEIGHT_BW-1:0] wk;
    logic signed [DATA_BW-1:0]   xk;
    logic signed [CALC_BW-1:0]   dot, base, total;
`ifdef PE_SATURATE_EN
    logic signed [CALC_BW-1:0]   sat_max, sat_min;
`endif

    // Stage 1 multiplies with the weights held before this edge, so a same-edge load
    // only affects later beats.
    always_comb begin
        w_d     = w_q;
        prod_d  = prod_q;
        psum1_d = psum1_q;
        mode1_d = mode1_q;
        clr1_d  = clr1_q;
        v1_d    = i_valid;
        wk      = '0;
        xk      = '0;
        if (i_w_en && i_addr == ADDR_BW'(ELEMENT_ADDR)) begin
            for (int k = 0; k < LANES; k++) begin
                w_d[k] = i_w[k*WEIGHT_BW +: WEIGHT_BW];
            end
        end
        if (i_valid) begin
            for (int k = 0; k < LANES; k++) begin
                wk        = w_q[k];
                xk        = i_x[k*DATA_BW +: DATA_BW];
                prod_d[k] = $signed({{DATA_BW{wk[WEIGHT_BW-1]}}, wk}) *
                            $signed({{WEIGHT_BW{xk[DATA_BW-1]}}, xk});
            end
            psum1_d = i_psum;
            mode1_d = i_acc_mode;
            clr1_d  = i_acc_clr;
        end
    end

    always_comb begin
        dot = '0;
        for (int k = 0; k < LANES; k++) begin
            dot = dot + CALC_BW'(prod_q[k]);
        end
        if (!mode1_q) begin
            base = CALC_BW'(psum1_q);
        end else if (clr1_q) begin
            base = '0;
        end else begin
            base = CALC_BW'($signed(psum2_q));
        end
        total = base + dot;
        v2_d  = v1_q;
`ifdef PE_SATURATE_EN
        sat_max = CALC_BW'({1'b0, {(OUT_BW-1){1'b1}}});
        sat_min = ~sat_max;
        if (total > sat_max) begin
            psum2_d = sat_max[OUT_BW-1:0];
        end else if (total < sat_min) begin
            psum2_d = sat_min[OUT_BW-1:0];
        end else begin
            psum2_d = total[OUT_BW-1:0];
        end
`else
        psum2_d = total;
`endif
        // Bubbles hold the output, which doubles as the accumulator.
        if (!v1_q) begin
            psum2_d = psum2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                w_q[k]    <= '0;
                prod_q[k] <= '0;
            end
            psum1_q <= '0;
            mode1_q <= 1'b0;
            clr1_q  <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            psum2_q <= '0;
        end else begin
            w_q     <= w_d;
            prod_q  <= prod_d;
            psum1_q <= psum1_d;
            mode1_q <= mode1_d;
            clr1_q  <= clr1_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            psum2_q <= psum2_d;
        end
    end

    assign o_valid = v2_q;
    assign o_psum  = psum2_q;
endmodule
